// File: rtl/mmio_input_ctrl.sv
// ============================================================================
// mmio_input_ctrl : debounced KEY/SW input device with registered MMIO reads
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_debounce #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] deb_o,
  output logic         upd_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  s1_q, s2_q;
  logic [W-1:0]  deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // s1_q is the synchronised value one edge ahead of s2_q, so a change is
  // seen as soon as it reaches the second stage and the count restarts there.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (s1_q != s2_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign deb_o = deb_q;
  assign upd_o = (deb_d != deb_q);

endmodule

module mmio_input_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114,
  parameter int               DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  output logic             intr
);

  logic [3:0] kdata;
  logic [9:0] sdata;
  logic       kupd, supd;

  // Buttons are active-low on the board; invert so 1 means pressed.
  mmio_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk   (clk),
    .reset (reset),
    .raw_i (~KEY),
    .deb_o (kdata),
    .upd_o (kupd)
  );

  mmio_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk   (clk),
    .reset (reset),
    .raw_i (SW),
    .deb_o (sdata),
    .upd_o (supd)
  );

  logic krdy_q, krdy_d, kovr_q, kovr_d, kie_q, kie_d;
  logic srdy_q, srdy_d, sovr_q, sovr_d, sie_q, sie_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             hit_q, hit_d;
  logic             intr_q, intr_d;

  logic sel_key, sel_sw, sel_kctrl, sel_sctrl;
  logic key_rd, sw_rd, kctrl_wr, sctrl_wr;
  logic [DBITS-1:0] kctrl_val, sctrl_val;
  logic unused_wr_bits;

  assign sel_key   = (addr == ADDR_KEY);
  assign sel_sw    = (addr == ADDR_SW);
  assign sel_kctrl = (addr == ADDR_KCTRL);
  assign sel_sctrl = (addr == ADDR_SCTRL);

  assign key_rd   = rd_en & sel_key;
  assign sw_rd    = rd_en & sel_sw;
  assign kctrl_wr = wr_en & sel_kctrl;
  assign sctrl_wr = wr_en & sel_sctrl;

  assign unused_wr_bits = ^{wr_data[DBITS-1:9], wr_data[7:3], wr_data[1:0]};

  always_comb begin
    kctrl_val    = '0;
    kctrl_val[0] = krdy_q;
    kctrl_val[2] = kovr_q;
    kctrl_val[8] = kie_q;
    sctrl_val    = '0;
    sctrl_val[0] = srdy_q;
    sctrl_val[2] = sovr_q;
    sctrl_val[8] = sie_q;
  end

  // An update arriving while Ready is still set flags overrun; that set
  // outranks a same-edge clear-by-write.
  always_comb begin
    krdy_d = kupd | (krdy_q & ~key_rd);
    kovr_d = kovr_q;
    if (kupd & krdy_q & ~key_rd)     kovr_d = 1'b1;
    else if (kctrl_wr & ~wr_data[2]) kovr_d = 1'b0;
    kie_d  = kctrl_wr ? wr_data[8] : kie_q;

    srdy_d = supd | (srdy_q & ~sw_rd);
    sovr_d = sovr_q;
    if (supd & srdy_q & ~sw_rd)      sovr_d = 1'b1;
    else if (sctrl_wr & ~wr_data[2]) sovr_d = 1'b0;
    sie_d  = sctrl_wr ? wr_data[8] : sie_q;

    intr_d = (kie_d & krdy_d) | (sie_d & srdy_d);
  end

  always_comb begin
    rdata_d = '0;
    hit_d   = 1'b0;
    if (rd_en) begin
      if (sel_key) begin
        rdata_d = {{(DBITS-4){1'b0}}, kdata};
        hit_d   = 1'b1;
      end else if (sel_sw) begin
        rdata_d = {{(DBITS-10){1'b0}}, sdata};
        hit_d   = 1'b1;
      end else if (sel_kctrl) begin
        rdata_d = kctrl_val;
        hit_d   = 1'b1;
      end else if (sel_sctrl) begin
        rdata_d = sctrl_val;
        hit_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      krdy_q  <= 1'b0;
      kovr_q  <= 1'b0;
      kie_q   <= 1'b0;
      srdy_q  <= 1'b0;
      sovr_q  <= 1'b0;
      sie_q   <= 1'b0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      krdy_q  <= krdy_d;
      kovr_q  <= kovr_d;
      kie_q   <= kie_d;
      srdy_q  <= srdy_d;
      sovr_q  <= sovr_d;
      sie_q   <= sie_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      intr_q  <= intr_d;
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign intr  = intr_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_input_ctrl.sv
// ============================================================================
// tb_mmio_input_ctrl : directed self-checking bench for mmio_input_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mmio_input_ctrl;

  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

  logic        clk, reset;
  logic [3:0]  KEY, KEY2;
  logic [9:0]  SW, SW2;
  logic [31:0] addr, addr2, wr_data, wr_data2;
  logic        rd_en, wr_en, rd_en2, wr_en2;
  logic [31:0] rdata, rdata2;
  logic        hit, intr, hit2, intr2;

  int n_cmp = 0;
  int n_err = 0;

  mmio_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .addr(addr),
    .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
    .rdata(rdata), .hit(hit), .intr(intr)
  );

  mmio_input_ctrl #(.DEBOUNCE_CYCLES(50000)) dut_long (
    .clk(clk), .reset(reset), .KEY(KEY2), .SW(SW2), .addr(addr2),
    .rd_en(rd_en2), .wr_en(wr_en2), .wr_data(wr_data2),
    .rdata(rdata2), .hit(hit2), .intr(intr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    addr  = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
  endtask

  initial begin
    reset = 1'b1;
    KEY = 4'hF; SW = '0; addr = '0; rd_en = 0; wr_en = 0; wr_data = '0;
    KEY2 = 4'hF; SW2 = '0; addr2 = '0; rd_en2 = 0; wr_en2 = 0; wr_data2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_hit", {31'b0, hit}, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);

    // 3-cycle glitch on KEY1
    KEY = 4'b1101;
    repeat (3) tick();
    KEY = 4'hF;
    repeat (10) tick();
    rd(A_KEY);
    chk("glitch_kdata", rdata, 32'h0);
    chk("glitch_hit", {31'b0, hit}, 32'h1);
    rd(A_KCTRL);
    chk("glitch_kctrl", rdata, 32'h0);

    // Latency: accepted on edge 6 after the change
    KEY = 4'b1110;
    for (int i = 0; i < 6; i++) rd(A_KCTRL);
    chk("lat_pre_edge6", rdata, 32'h0);
    rd(A_KCTRL);
    chk("lat_ready", rdata, 32'h1);
    rd(A_KEY);
    chk("lat_kdata", rdata, 32'h1);
    rd(A_KCTRL);
    chk("lat_ready_clr", rdata, 32'h0);

    // Ready / Overrun / IE / intr
    wr(A_KCTRL, 32'h100);
    rd(A_KCTRL);
    chk("ie_set", rdata, 32'h100);
    KEY = 4'b1100;
    repeat (10) tick();
    chk("intr_set", {31'b0, intr}, 32'h1);
    KEY = 4'b1110;
    repeat (10) tick();
    rd(A_KCTRL);
    chk("ovr_kctrl", rdata, 32'h105);
    chk("ovr_intr", {31'b0, intr}, 32'h1);
    rd(A_KEY);
    chk("ovr_kdata", rdata, 32'h1);
    chk("intr_drop", {31'b0, intr}, 32'h0);
    rd(A_KCTRL);
    chk("ovr_after_rd", rdata, 32'h104);
    wr(A_KCTRL, 32'h104);
    rd(A_KCTRL);
    chk("ovr_wr1_noeff", rdata, 32'h104);
    wr(A_KCTRL, 32'h100);
    rd(A_KCTRL);
    chk("ovr_wr0_clr", rdata, 32'h100);

    // SW update coinciding with an SDATA read while Ready=1
    SW = 10'h001;
    repeat (10) tick();
    rd(A_SCTRL);
    chk("sw_ready", rdata, 32'h1);
    SW = 10'h3FF;
    repeat (5) tick();
    rd(A_SW);
    chk("sim_old_sdata", rdata, 32'h001);
    rd(A_SCTRL);
    chk("sim_sctrl", rdata, 32'h001);
    rd(A_SW);
    chk("sim_new_sdata", rdata, 32'h3FF);

    // Address decode
    rd(32'hF0000018);
    chk("dec1_rdata", rdata, 32'h0);
    chk("dec1_hit", {31'b0, hit}, 32'h0);
    rd(32'h00000010);
    chk("dec2_rdata", rdata, 32'h0);
    chk("dec2_hit", {31'b0, hit}, 32'h0);
    wr(A_KEY, 32'hFFFFFFFF);
    rd(A_KEY);
    chk("kdata_ro", rdata, 32'h1);
    chk("kdata_ro_hit", {31'b0, hit}, 32'h1);

    // Asynchronous reset mid-cycle with outputs active
    KEY = 4'hF;
    SW  = '0;
    repeat (10) tick();
    chk("pre_rst_intr", {31'b0, intr}, 32'h1);
    addr  = A_KCTRL;
    rd_en = 1'b1;
    tick();
    chk("pre_rst_rdata", rdata, 32'h101);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_hit", {31'b0, hit}, 32'h0);
    chk("async_rst_intr", {31'b0, intr}, 32'h0);
    rd_en = 1'b0;
    addr  = '0;
    tick();
    reset = 1'b0;
    rd(A_KEY);
    chk("post_rst_kdata", rdata, 32'h0);
    chk("post_rst_hit", {31'b0, hit}, 32'h1);

    // Long debounce: SDATA read continuously, so rdata2 lags SDATA by one edge
    addr2  = A_SW;
    rd_en2 = 1'b1;
    for (int t = 0; t < 20; t++) begin
      SW2 = (t % 2 == 0) ? 10'h2AA : 10'h000;
      repeat (1000) tick();
      chk("long_toggle", rdata2, 32'h0);
    end
    SW2 = 10'h155;
    repeat (50002) tick();
    chk("long_pre_edge", rdata2, 32'h0);
    tick();
    chk("long_accept", rdata2, 32'h155);
    chk("long_hit", {31'b0, hit2}, 32'h1);
    chk("long_intr", {31'b0, intr2}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
